jt6295_ch_fetch: RTL and testbench
==================================

// Module: jt6295_ch_fetch
// PURPOSE
//  Four-channel ADPCM nibble fetcher, directly downstream of the phrase-table
//  controller. It latches per-channel start/stop addresses and attenuation on
//  start requests, walks each channel's ROM range one nibble per sample
//  period, and reports busy status back to the controller. It feeds one
//  nibble per active channel slot to the ADPCM decoder stage.
// PARAMETERS
//  (none) channel count fixed at 4; ROM address width fixed at 18.
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous active-high reset
//  cen          in   1   slot enable; 4 cen pulses = 1 sample period, >=8 clk apart
//  start_addr   in   18  phrase start byte address (valid while start edge seen)
//  stop_addr    in   18  phrase last byte address (inclusive)
//  att          in   4   phrase attenuation
//  start        in   4   per-channel start request, rising edge acts
//  stop         in   4   per-channel stop, level-sensitive
//  busy         out  4   channel i playing
//  rom_addr     out  18  sample ROM byte address
//  rom_cs       out  1   ROM request
//  rom_data     in   8   ROM data
//  rom_ok       in   1   ROM data valid for current rom_addr
//  dout_ch      out  2   channel of emitted nibble
//  dout_nib     out  4   ADPCM nibble
//  dout_att     out  4   channel attenuation
//  dout_first   out  1   first nibble of phrase (decoder predictor reset)
//  dout_valid   out  1   one-clk strobe qualifying dout_*
// BEHAVIOUR
//  Reset: busy=0, rom_cs=0, rom_addr=0, dout_*=0, slot=0, FSM=IDLE, all channel regs 0.
//  Per channel i: ptr[18:0] nibble address {byte,lsb}, end[17:0], att[3:0],
//   byte buffer[7:0], first flag.
//  Start: start[i]&~start_d[i] & ~stop[i] -> ptr={start_addr,0}, end=stop_addr,
//   att latched, first=1, busy[i]=1 next clk. Accepted any cycle; restarts a busy ch.
//  Stop: stop[i]=1 -> busy[i]=0 next clk; overrides a same-cycle start edge.
//   If stop hits the channel currently in REQ, FSM aborts to IDLE, no dout_valid.
//  Slot counter: 2-bit, increments on cen, wraps 3->0. A cen with FSM not in IDLE
//   aborts that slot: rom_cs=0, no output, ptr unchanged (retried next period).
//  FSM:
//   IDLE: on cen, slot s=new slot value; if !busy[s] stay IDLE.
//    if busy[s] & ptr[0]==0 -> REQ, rom_addr=ptr[18:1], rom_cs=1.
//    if busy[s] & ptr[0]==1 -> EMIT (use buffered byte, no ROM access).
//   REQ: ignore rom_ok on first REQ cycle; on first later cycle with rom_ok=1
//    capture rom_data into buffer, rom_cs=0 -> EMIT.
//   EMIT (1 clk): dout_valid=1, dout_ch=s, dout_nib = ptr[0]?buf[3:0]:buf[7:4]
//    (high nibble first), dout_att=att[s], dout_first=first[s]; first[s]=0;
//    if ptr[0]==1 && ptr[18:1]==end[s] -> busy[s]=0 else ptr+=1; -> IDLE.
//  Wrap: ptr increments modulo 2^19 (0x3FFFF byte wraps to 0); stop_addr<start_addr
//   plays through wrap. end compare is exact byte equality.
//  Latency: cen to dout_valid = 1 clk (buffered nibble) or 2 + ROM wait clks.
//  dout_* hold last value when dout_valid=0; dout_valid never high twice per cen.
//  Start edge during EMIT of same channel: start wins, emitted nibble still output.
// TESTING
//  start[0] edge, start_addr=0x00100, stop_addr=0x00101, rom_ok 1 clk later, bytes
//   0xA5,0x3C -> ch0 nibbles A,5,3,C, dout_first on A only, busy[0] drops after C.
//  start_addr=0x3FFFF, stop_addr=0x00000 -> fetch 0x3FFFF then 0x00000, 4 nibbles, busy clears.
//  ch0..3 started together -> dout_ch sequence 1,2,3,0,... one nibble each per period.
//  stop[2]=1 while ch2 in REQ -> rom_cs drops, no dout_valid for slot 2, busy[2]=0 next clk.
//  rom_ok held low past next cen -> slot aborted, same nibble address re-requested next period.
//  start and stop same cycle on ch1 -> busy[1] stays 0; rst mid-REQ -> all outputs reset values.

Source files
------------

// File: rtl/jt6295_ch_fetch.sv
// Four-channel ADPCM nibble fetcher.
// Holds per-channel phrase pointers and walks them one nibble per sample
// period. Each byte is read once from ROM: its high nibble is sent on the
// even slot visit, and its buffered low nibble is sent on the next visit.
module jt6295_ch_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [17:0] start_addr,
    input  logic [17:0] stop_addr,
    input  logic [3:0]  att,
    input  logic [3:0]  start,
    input  logic [3:0]  stop,
    output logic [3:0]  busy,
    output logic [17:0] rom_addr,
    output logic        rom_cs,
    input  logic [7:0]  rom_data,
    input  logic        rom_ok,
    output logic [1:0]  dout_ch,
    output logic [3:0]  dout_nib,
    output logic [3:0]  dout_att,
    output logic        dout_first,
    output logic        dout_valid
);

    localparam int unsigned NCH = 4;
    localparam int unsigned AW  = 18;
    localparam int unsigned PW  = AW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [1:0]    slot;
    logic [1:0]    slot_inc;
    logic          req_armed;
    logic [3:0]    start_d;
    logic [3:0]    st_edge;

    logic [PW-1:0] ptr       [NCH];
    logic [AW-1:0] last_addr [NCH];
    logic [3:0]    ch_att    [NCH];
    logic [7:0]    nbuf      [NCH];
    logic [3:0]    first;

    logic          do_req;
    logic          do_emit;
    logic          emit_rom;
    logic [1:0]    emit_ch;
    logic [PW-1:0] emit_ptr;
    logic [7:0]    emit_byte;
    logic [3:0]    emit_nib;
    logic          emit_done;

    assign slot_inc = slot + 2'd1;
    // A start edge is dropped when stop is asserted on the same channel.
    assign st_edge  = start & ~start_d & ~stop;

    // Next-state logic: dispatch a slot on cen, wait for ROM, emit one nibble.
    always_comb begin
        state_nxt = state;
        do_req    = 1'b0;
        do_emit   = 1'b0;
        emit_rom  = 1'b0;
        emit_ch   = slot;
        case (state)
            ST_IDLE: begin
                if (cen && busy[slot_inc] && !stop[slot_inc]) begin
                    emit_ch = slot_inc;
                    if (ptr[slot_inc][0]) begin
                        state_nxt = ST_EMIT;
                        do_emit   = 1'b1;
                    end else begin
                        state_nxt = ST_REQ;
                        do_req    = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                // A new cen abandons the slot; the pointer is left for a retry.
                if (cen || stop[slot] || !busy[slot]) begin
                    state_nxt = ST_IDLE;
                end else if (req_armed && rom_ok) begin
                    state_nxt = ST_EMIT;
                    do_emit   = 1'b1;
                    emit_rom  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Nibble selection and end-of-phrase detection for the emitting channel.
    always_comb begin
        emit_ptr  = ptr[emit_ch];
        emit_byte = emit_rom ? rom_data : nbuf[emit_ch];
        emit_nib  = emit_ptr[0] ? emit_byte[3:0] : emit_byte[7:4];
        emit_done = emit_ptr[0] && (emit_ptr[PW-1:1] == last_addr[emit_ch]);
    end

    // State register, slot counter and start-edge history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            slot      <= 2'd0;
            req_armed <= 1'b0;
            start_d   <= 4'd0;
        end else begin
            state     <= state_nxt;
            if (cen) slot <= slot_inc;
            // rom_ok is only trusted after the first REQ cycle.
            req_armed <= (state == ST_REQ) && (state_nxt == ST_REQ);
            start_d   <= start;
        end
    end

    // ROM request port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_cs   <= 1'b0;
            rom_addr <= 18'd0;
        end else begin
            rom_cs <= (state_nxt == ST_REQ);
            if (do_req) rom_addr <= ptr[slot_inc][PW-1:1];
        end
    end

    // Decoder-facing output; holds its last value between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid <= 1'b0;
            dout_ch    <= 2'd0;
            dout_nib   <= 4'd0;
            dout_att   <= 4'd0;
            dout_first <= 1'b0;
        end else begin
            dout_valid <= do_emit;
            if (do_emit) begin
                dout_ch    <= emit_ch;
                dout_nib   <= emit_nib;
                dout_att   <= ch_att[emit_ch];
                dout_first <= first[emit_ch];
            end
        end
    end

    // Per-channel phrase registers: stop beats start, start beats emit advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 4'd0;
            first <= 4'd0;
            for (int i = 0; i < NCH; i++) begin
                ptr[i]       <= PW'(0);
                last_addr[i] <= AW'(0);
                ch_att[i]    <= 4'd0;
                nbuf[i]      <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (do_emit && emit_rom && (emit_ch == 2'(i))) nbuf[i] <= rom_data;
                if (stop[i]) begin
                    busy[i] <= 1'b0;
                end else if (st_edge[i]) begin
                    ptr[i]       <= {start_addr, 1'b0};
                    last_addr[i] <= stop_addr;
                    ch_att[i]    <= att;
                    first[i]     <= 1'b1;
                    busy[i]      <= 1'b1;
                end else if (do_emit && (emit_ch == 2'(i))) begin
                    first[i] <= 1'b0;
                    if (emit_done) busy[i] <= 1'b0;
                    else           ptr[i]  <= ptr[i] + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_jt6295_ch_fetch.sv
// Testbench for jt6295_ch_fetch: phrase table, hand-written corner cases and
// a randomized run against a phrase-level reference model.
`timescale 1ns/1ps
module tb_jt6295_ch_fetch;

    logic        clk = 1'b0;
    logic        rst, cen;
    logic [17:0] start_addr, stop_addr;
    logic [3:0]  att, start, stop;
    logic [3:0]  busy;
    logic [17:0] rom_addr;
    logic        rom_cs;
    logic [7:0]  rom_data;
    logic        rom_ok;
    logic [1:0]  dout_ch;
    logic [3:0]  dout_nib, dout_att;
    logic        dout_first, dout_valid;

    jt6295_ch_fetch dut (
        .clk(clk), .rst(rst), .cen(cen),
        .start_addr(start_addr), .stop_addr(stop_addr), .att(att),
        .start(start), .stop(stop), .busy(busy),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
        .dout_ch(dout_ch), .dout_nib(dout_nib), .dout_att(dout_att),
        .dout_first(dout_first), .dout_valid(dout_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ch;
        logic [3:0] nib;
        logic [3:0] at;
        logic       first;
        int         lat;
    } obs_t;

    typedef struct {
        logic [1:0]  ch;
        logic [17:0] sa;
        logic [17:0] ea;
        logic [3:0]  at;
        int          lat;
        logic [7:0]  b0;
        logic [7:0]  b1;
        int          n;
        logic [15:0] nibs;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int cen_cyc  = 0;
    int slot_m   = 0;
    int rom_lat  = 1;
    int rom_cnt  = 0;

    logic [7:0] rom_mem [0:262143];
    obs_t       got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Sample ROM with a programmable number of clocks from rom_cs to rom_ok.
    always @(negedge clk) begin
        if (rom_cs) begin
            rom_cnt = rom_cnt + 1;
            rom_ok  = (rom_cnt >= rom_lat);
        end else begin
            rom_cnt = 0;
            rom_ok  = 1'b0;
        end
        rom_data = rom_mem[rom_addr];
    end

    // Collect every output strobe with its latency from the cen clock.
    always @(negedge clk) begin
        if (dout_valid) begin
            obs_t o;
            o.ch = dout_ch; o.nib = dout_nib; o.at = dout_att; o.first = dout_first;
            o.lat = cyc - cen_cyc;
            got_q.push_back(o);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rom_lat_exp(input int l);
        return ((l > 2) ? l : 2) + 1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        slot_m = 0;
        got_q.delete();
    endtask

    // One sample-period slot: cen for one clock, then 9 quiet clocks.
    task automatic do_cen();
        cen_cyc = cyc;
        cen = 1'b1;
        @(negedge clk);
        cen = 1'b0;
        slot_m = (slot_m + 1) % 4;
        repeat (9) @(negedge clk);
    endtask

    task automatic start_phrase(input int ch, input logic [17:0] sa, input logic [17:0] ea,
                                input logic [3:0] a);
        start_addr = sa; stop_addr = ea; att = a;
        start[ch] = 1'b1;
        @(negedge clk);
        start = 4'd0;
        @(negedge clk);
    endtask

    task automatic wait_req(input string name);
        for (int c = 0; c < 8 && !rom_cs; c++) do_cen();
        check(name, 32'(rom_cs), 32'd1);
    endtask

    vec_t        tbl[4];
    obs_t        o;
    int          k;
    logic [3:0]  exp_nib;
    logic [7:0]  byte_v;
    logic [3:0]  m_busy;
    logic [17:0] m_sa  [4];
    logic [3:0]  m_att [4];
    int          m_len [4];
    int          m_n   [4];

    initial begin
        rst = 1'b1; cen = 1'b0; start = 4'd0; stop = 4'd0;
        start_addr = 18'd0; stop_addr = 18'd0; att = 4'd0;
        rom_ok = 1'b0; rom_data = 8'd0;
        for (int a = 0; a < 262144; a++) rom_mem[a] = 8'((a * 37) ^ (a >> 5) ^ 90);

        tbl[0] = '{ch: 2'd0, sa: 18'h00100, ea: 18'h00101, at: 4'h5, lat: 1,
                   b0: 8'hA5, b1: 8'h3C, n: 4, nibs: 16'hA53C};
        tbl[1] = '{ch: 2'd1, sa: 18'h3FFFF, ea: 18'h00000, at: 4'h9, lat: 2,
                   b0: 8'h12, b1: 8'h34, n: 4, nibs: 16'h1234};
        tbl[2] = '{ch: 2'd2, sa: 18'h20000, ea: 18'h20000, at: 4'hF, lat: 0,
                   b0: 8'h7E, b1: 8'h00, n: 2, nibs: 16'h7E00};
        tbl[3] = '{ch: 2'd3, sa: 18'h0ABCD, ea: 18'h0ABCE, at: 4'h0, lat: 3,
                   b0: 8'hF0, b1: 8'h0F, n: 4, nibs: 16'hF00F};

        @(negedge clk);
        do_reset();

        // Reset values
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rom_cs", 32'(rom_cs), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_dout", {dout_ch, dout_nib, dout_att, dout_first}, 32'd0);

        // Phrase table, one channel at a time
        for (int v = 0; v < 4; v++) begin
            rom_mem[tbl[v].sa]             = tbl[v].b0;
            rom_mem[18'(tbl[v].sa + 18'd1)] = tbl[v].b1;
            rom_lat = tbl[v].lat;
            start_phrase(int'(tbl[v].ch), tbl[v].sa, tbl[v].ea, tbl[v].at);
            got_q.delete();
            k = 0;
            for (int c = 0; c < 16 && k < tbl[v].n; c++) begin
                do_cen();
                if (got_q.size() > 0) begin
                    o = got_q.pop_front();
                    exp_nib = tbl[v].nibs[15 - 4*k -: 4];
                    check("tbl_ch", 32'(o.ch), 32'(tbl[v].ch));
                    check("tbl_nib", 32'(o.nib), 32'(exp_nib));
                    check("tbl_att", 32'(o.at), 32'(tbl[v].at));
                    check("tbl_first", 32'(o.first), 32'(k == 0));
                    check("tbl_lat", 32'(o.lat), 32'((k % 2) ? 1 : rom_lat_exp(tbl[v].lat)));
                    check("tbl_busy", 32'(busy[tbl[v].ch]), 32'(k + 1 < tbl[v].n));
                    check("tbl_extra", 32'(got_q.size()), 32'd0);
                    k++;
                end
            end
            check("tbl_count", 32'(k), 32'(tbl[v].n));
        end

        // All four channels together: round-robin order from slot 1
        do_reset();
        rom_lat = 1;
        rom_mem[18'h00200] = 8'h96;
        start_addr = 18'h00200; stop_addr = 18'h00200; att = 4'h3;
        start = 4'hF;
        @(negedge clk);
        start = 4'd0;
        @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            do_cen();
            check("rr_count", 32'(got_q.size()), 32'd1);
            if (got_q.size() > 0) begin
                o = got_q.pop_front();
                check("rr_ch", 32'(o.ch), 32'((j + 1) % 4));
                check("rr_nib", 32'(o.nib), (j < 4) ? 32'h9 : 32'h6);
                check("rr_first", 32'(o.first), 32'(j < 4));
            end
        end
        check("rr_busy", 32'(busy), 32'd0);

        // Start and stop in the same cycle: stop wins
        start_addr = 18'h00400; stop_addr = 18'h00401; att = 4'h1;
        start = 4'b0011; stop = 4'b0010;
        @(negedge clk);
        start = 4'd0; stop = 4'd0;
        check("ss_busy1", 32'(busy[1]), 32'd0);
        check("ss_busy0", 32'(busy[0]), 32'd1);
        stop[0] = 1'b1;
        @(negedge clk);
        stop = 4'd0;
        check("ss_stop0", 32'(busy), 32'd0);

        // Stop while ch2 waits on ROM
        rom_lat = 100;
        start_phrase(2, 18'h00300, 18'h00305, 4'h4);
        got_q.delete();
        wait_req("stop_req_seen");
        check("stop_req_addr", 32'(rom_addr), 32'h00300);
        stop[2] = 1'b1;
        @(negedge clk);
        stop = 4'd0;
        check("stop_rom_cs", 32'(rom_cs), 32'd0);
        check("stop_busy2", 32'(busy[2]), 32'd0);
        repeat (10) @(negedge clk);
        check("stop_no_dout", 32'(got_q.size()), 32'd0);

        // ROM too slow: slot aborted by the next cen and retried
        start_phrase(3, 18'h01234, 18'h01240, 4'h6);
        got_q.delete();
        wait_req("slow_req_seen");
        check("slow_req_addr", 32'(rom_addr), 32'h01234);
        do_cen();
        check("slow_abort_cs", 32'(rom_cs), 32'd0);
        check("slow_abort_dout", 32'(got_q.size()), 32'd0);
        check("slow_busy", 32'(busy[3]), 32'd1);
        rom_lat = 1;
        repeat (2) do_cen();
        check("slow_idle_slots", 32'(got_q.size()), 32'd0);
        do_cen();
        check("retry_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) begin
            o = got_q.pop_front();
            byte_v = rom_mem[18'h01234];
            check("retry_nib", 32'(o.nib), 32'(byte_v[7:4]));
            check("retry_first", 32'(o.first), 32'd1);
            check("retry_ch", 32'(o.ch), 32'd3);
        end
        check("retry_addr", 32'(rom_addr), 32'h01234);
        stop[3] = 1'b1;
        @(negedge clk);
        stop = 4'd0;

        // Reset while a ROM request is outstanding
        rom_lat = 100;
        start_phrase(0, 18'h05000, 18'h05001, 4'h8);
        wait_req("rstreq_seen");
        rst = 1'b1;
        @(negedge clk);
        check("rstreq_busy", 32'(busy), 32'd0);
        check("rstreq_cs", 32'(rom_cs), 32'd0);
        check("rstreq_addr", 32'(rom_addr), 32'd0);
        check("rstreq_valid", 32'(dout_valid), 32'd0);
        check("rstreq_dout", {dout_ch, dout_nib, dout_att, dout_first}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        slot_m = 0;
        got_q.delete();

        // Randomized run against a phrase-level model
        m_busy = 4'd0;
        for (int i = 0; i < 4; i++) begin m_n[i] = 0; m_len[i] = 0; m_sa[i] = 18'd0; m_att[i] = 4'd0; end
        for (int p = 0; p < 300; p++) begin
            int s, len, st_ch, sp_ch;
            logic do_st, do_sp;
            logic [17:0] sa;
            logic [3:0] a;
            rom_lat = $urandom_range(0, 4);
            do_cen();
            s = slot_m;
            if (m_busy[s]) begin
                check("rnd_count", 32'(got_q.size()), 32'd1);
                if (got_q.size() > 0) begin
                    o = got_q.pop_front();
                    byte_v = rom_mem[18'(m_sa[s] + 18'(m_n[s] / 2))];
                    exp_nib = (m_n[s] % 2) ? byte_v[3:0] : byte_v[7:4];
                    check("rnd_ch", 32'(o.ch), 32'(s));
                    check("rnd_nib", 32'(o.nib), 32'(exp_nib));
                    check("rnd_att", 32'(o.at), 32'(m_att[s]));
                    check("rnd_first", 32'(o.first), 32'(m_n[s] == 0));
                    check("rnd_lat", 32'(o.lat), 32'((m_n[s] % 2) ? 1 : rom_lat_exp(rom_lat)));
                end
                m_n[s]++;
                if (m_n[s] == m_len[s]) m_busy[s] = 1'b0;
            end else begin
                check("rnd_none", 32'(got_q.size()), 32'd0);
            end
            got_q.delete();
            check("rnd_busy", 32'(busy), 32'(m_busy));

            st_ch = $urandom_range(0, 3);
            sp_ch = $urandom_range(0, 3);
            do_st = ($urandom_range(0, 1) == 0);
            do_sp = ($urandom_range(0, 5) == 0);
            sa    = ($urandom_range(0, 3) == 0) ? 18'(18'h3FFFE + 18'($urandom_range(0, 1)))
                                                : 18'($urandom);
            len   = $urandom_range(0, 2);
            a     = 4'($urandom);
            start_addr = sa; stop_addr = 18'(sa + 18'(len)); att = a;
            start[st_ch] = do_st;
            stop[sp_ch]  = do_sp;
            @(negedge clk);
            start = 4'd0; stop = 4'd0;
            @(negedge clk);
            if (do_sp) m_busy[sp_ch] = 1'b0;
            if (do_st && !(do_sp && sp_ch == st_ch)) begin
                m_busy[st_ch] = 1'b1;
                m_sa[st_ch]   = sa;
                m_att[st_ch]  = a;
                m_len[st_ch]  = 2 * (len + 1);
                m_n[st_ch]    = 0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
